// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch in the clkin domain, advanced by rising edges of the sampled div_clk.
// Run/pause/done FSM, lap hold of the displayed digits, optional wrap at 59:59.

module stopwatch_bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       i_clkin,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_inc,
    output logic [3:0] o_digit,
    output logic       o_at_max
);
    logic [3:0] r_digit;

    always_ff @(posedge i_clkin) begin
        if (i_rst || i_clear)
            r_digit <= 4'd0;
        else if (i_inc)
            r_digit <= (r_digit >= MAX) ? 4'd0 : r_digit + 4'd1;
    end

    assign o_digit  = r_digit;
    assign o_at_max = (r_digit >= MAX);
endmodule

module stopwatch_bcd #(
    parameter int TICKS_PER_SEC = 1,
    parameter int WRAP_EN       = 1
) (
    input  logic       i_clkin,
    input  logic       i_rst,
    input  logic       i_div_clk,
    input  logic       i_start_stop,
    input  logic       i_clear,
    input  logic       i_lap,
    output logic [3:0] o_sec_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_min_tens,
    output logic       o_running,
    output logic       o_lap_active,
    output logic       o_wrap
);
    localparam int NUM_DIG = 4;
    // Digit 0 is sec_ones, digit 3 is min_tens.
    localparam logic [NUM_DIG-1:0][3:0] DIG_MAX   = {4'd5, 4'd9, 4'd5, 4'd9};
    localparam logic [7:0]              PCNT_LAST = 8'(TICKS_PER_SEC - 1);
    localparam bit                      WRAP      = (WRAP_EN != 0);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t                  r_state;
    logic                    r_running;
    logic                    r_div_q;
    logic                    r_lap;
    logic                    r_wrap;
    logic [7:0]              r_pcnt;
    logic [NUM_DIG-1:0][3:0] r_held;
    logic [NUM_DIG-1:0][3:0] r_disp;
    logic [NUM_DIG-1:0][3:0] w_live;
    logic [NUM_DIG-1:0]      w_at_max;
    logic [NUM_DIG-1:0]      w_inc;
    logic                    w_tick;
    logic                    w_cnt_en;
    logic                    w_sec_step;
    logic                    w_term;
    logic                    w_sat;
    logic                    w_lap_nxt;

    assign w_tick     = i_div_clk & ~r_div_q;
    assign w_cnt_en   = w_tick && (r_state == S_RUN) && !i_clear;
    assign w_sec_step = w_cnt_en && (r_pcnt == PCNT_LAST);
    assign w_term     = &w_at_max;
    assign w_sat      = w_sec_step && w_term && !WRAP;
    assign w_inc[0]   = w_sec_step && !w_sat;
    assign w_lap_nxt  = i_clear ? 1'b0 : (r_lap ^ i_lap);

    genvar g;
    generate
        for (g = 1; g < NUM_DIG; g++) begin : g_carry
            assign w_inc[g] = w_inc[g-1] & w_at_max[g-1];
        end
        for (g = 0; g < NUM_DIG; g++) begin : g_dig
            stopwatch_bcd_digit #(.MAX(DIG_MAX[g])) u_dig (
                .i_clkin  (i_clkin),
                .i_rst    (i_rst),
                .i_clear  (i_clear),
                .i_inc    (w_inc[g]),
                .o_digit  (w_live[g]),
                .o_at_max (w_at_max[g])
            );
        end
    endgenerate

    always_ff @(posedge i_clkin) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_div_q   <= 1'b0;
            r_lap     <= 1'b0;
            r_wrap    <= 1'b0;
            r_pcnt    <= 8'd0;
            r_held    <= '0;
            r_disp    <= '0;
        end else begin
            r_div_q <= i_div_clk;
            r_wrap  <= w_sec_step && w_term && WRAP;

            if (i_clear)
                r_pcnt <= 8'd0;
            else if (w_cnt_en)
                r_pcnt <= (r_pcnt == PCNT_LAST) ? 8'd0 : r_pcnt + 8'd1;

            // Saturation beats a same-edge start_stop: the run is over.
            if (i_clear) begin
                r_state   <= S_IDLE;
                r_running <= 1'b0;
            end else if (w_sat) begin
                r_state   <= S_DONE;
                r_running <= 1'b0;
            end else if (i_start_stop) begin
                unique case (r_state)
                    S_IDLE, S_PAUSE: begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                    S_RUN: begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end
                    default: ;
                endcase
            end

            r_lap <= w_lap_nxt;
            if (i_clear)
                r_held <= '0;
            else if (i_lap && !r_lap)
                r_held <= w_live;

            // Hold only while lap was already set; on set the held copy equals live time.
            r_disp <= (r_lap && w_lap_nxt) ? r_held : w_live;
        end
    end

    assign o_sec_ones   = r_disp[0];
    assign o_sec_tens   = r_disp[1];
    assign o_min_ones   = r_disp[2];
    assign o_min_tens   = r_disp[3];
    assign o_running    = r_running;
    assign o_lap_active = r_lap;
    assign o_wrap       = r_wrap;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench: three stopwatch_bcd instances (wrap, saturate, 3 ticks/sec) on shared stimulus.

module tb_stopwatch_bcd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic div_clk = 1'b0;
    logic ss = 1'b0;
    logic clr = 1'b0;
    logic lap = 1'b0;

    wire [15:0] t_a, t_b, t_c;
    wire run_a, run_b, run_c, lap_a, lap_b, lap_c, wrap_a, wrap_b, wrap_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stopwatch_bcd #(.TICKS_PER_SEC(1), .WRAP_EN(1)) u_a (
        .i_clkin(clk), .i_rst(rst), .i_div_clk(div_clk), .i_start_stop(ss),
        .i_clear(clr), .i_lap(lap),
        .o_sec_ones(t_a[3:0]), .o_sec_tens(t_a[7:4]), .o_min_ones(t_a[11:8]),
        .o_min_tens(t_a[15:12]), .o_running(run_a), .o_lap_active(lap_a), .o_wrap(wrap_a));

    stopwatch_bcd #(.TICKS_PER_SEC(1), .WRAP_EN(0)) u_b (
        .i_clkin(clk), .i_rst(rst), .i_div_clk(div_clk), .i_start_stop(ss),
        .i_clear(clr), .i_lap(lap),
        .o_sec_ones(t_b[3:0]), .o_sec_tens(t_b[7:4]), .o_min_ones(t_b[11:8]),
        .o_min_tens(t_b[15:12]), .o_running(run_b), .o_lap_active(lap_b), .o_wrap(wrap_b));

    stopwatch_bcd #(.TICKS_PER_SEC(3), .WRAP_EN(1)) u_c (
        .i_clkin(clk), .i_rst(rst), .i_div_clk(div_clk), .i_start_stop(ss),
        .i_clear(clr), .i_lap(lap),
        .o_sec_ones(t_c[3:0]), .o_sec_tens(t_c[7:4]), .o_min_ones(t_c[11:8]),
        .o_min_tens(t_c[15:12]), .o_running(run_c), .o_lap_active(lap_c), .o_wrap(wrap_c));

    typedef struct {
        string       name;
        bit          ss;
        bit          clr;
        bit          lap;
        int          n;
        logic [15:0] t;
        bit          run;
        bit          lp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One div_clk period: 4 clkin high, 4 low; called and returns at a negedge.
    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            div_clk = 1'b1;
            repeat (4) @(negedge clk);
            div_clk = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic pulse(input int which);
        case (which)
            0: ss = 1'b1;
            1: clr = 1'b1;
            default: lap = 1'b1;
        endcase
        @(negedge clk);
        ss = 1'b0; clr = 1'b0; lap = 1'b0;
        @(negedge clk);
    endtask

    // div_clk rises on the same edge that samples a control pulse (0 = start_stop, 1 = clear).
    task automatic pulse_on_tick(input int which);
        div_clk = 1'b1;
        if (which == 0) ss = 1'b1; else clr = 1'b1;
        @(negedge clk);
        ss = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        div_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int wa, wb;
        vecs[0] = '{"idle20",   0, 0, 0, 20, 16'h0000, 0, 0};
        vecs[1] = '{"run75",    1, 0, 0, 75, 16'h0115, 1, 0};
        vecs[2] = '{"pause10",  1, 0, 0, 10, 16'h0115, 0, 0};
        vecs[3] = '{"resume1",  1, 0, 0,  1, 16'h0116, 1, 0};
        vecs[4] = '{"clear",    0, 1, 0,  0, 16'h0000, 0, 0};
        vecs[5] = '{"run10",    1, 0, 0, 10, 16'h0010, 1, 0};
        vecs[6] = '{"lap_hold", 0, 0, 1,  5, 16'h0010, 1, 1};
        vecs[7] = '{"lap_rel",  0, 0, 1,  0, 16'h0015, 1, 0};
        vecs[8] = '{"clear2",   0, 1, 0,  0, 16'h0000, 0, 0};

        // Reset held while div_clk toggles.
        @(negedge clk);
        ticks(3);
        check("rst_time", 32'(t_a), 32'h0000);
        check("rst_run", 32'(run_a), 32'd0);
        check("rst_lap", 32'(lap_a), 32'd0);
        check("rst_wrap", 32'(wrap_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].ss)  pulse(0);
            if (vecs[i].clr) pulse(1);
            if (vecs[i].lap) pulse(2);
            ticks(vecs[i].n);
            @(negedge clk);
            check({vecs[i].name, "_time"}, 32'(t_a), 32'(vecs[i].t));
            check({vecs[i].name, "_run"}, 32'(run_a), 32'(vecs[i].run));
            check({vecs[i].name, "_lap"}, 32'(lap_a), 32'(vecs[i].lp));
            check({vecs[i].name, "_time_b"}, 32'(t_b), 32'(vecs[i].t));
        end

        // Count to 59:59, then the terminal tick.
        pulse(0);
        ticks(3599);
        @(negedge clk);
        check("full_a", 32'(t_a), 32'h5959);
        check("full_b", 32'(t_b), 32'h5959);
        wa = 0; wb = 0;
        div_clk = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) div_clk = 1'b0;
            @(negedge clk);
            if (wrap_a) wa++;
            if (wrap_b) wb++;
        end
        @(negedge clk);
        check("wrap_cycles_a", 32'(wa), 32'd1);
        check("wrap_cycles_b", 32'(wb), 32'd0);
        check("wrapped_a", 32'(t_a), 32'h0000);
        check("wrapped_run_a", 32'(run_a), 32'd1);
        check("sat_b", 32'(t_b), 32'h5959);
        check("done_run_b", 32'(run_b), 32'd0);
        pulse(0);
        ticks(2);
        check("done_ss_b", 32'(run_b), 32'd0);
        check("done_hold_b", 32'(t_b), 32'h5959);
        check("pause_a", 32'(run_a), 32'd0);
        pulse(1);
        check("done_clear_b", 32'(t_b), 32'h0000);
        pulse(0);
        ticks(1);
        check("idle_restart_b", 32'(t_b), 32'h0001);
        check("idle_restart_a", 32'(t_a), 32'h0001);

        // Same-edge control and tick.
        pulse_on_tick(1);
        @(negedge clk);
        check("clr_tick_time", 32'(t_a), 32'h0000);
        check("clr_tick_run", 32'(run_a), 32'd0);
        pulse(0);
        ticks(2);
        check("rerun", 32'(t_a), 32'h0002);
        pulse_on_tick(0);
        check("ss_tick_time", 32'(t_a), 32'h0003);
        check("ss_tick_run", 32'(run_a), 32'd0);
        ticks(2);
        check("ss_tick_paused", 32'(t_a), 32'h0003);

        // Prescaler with three ticks per second.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse(0);
        ticks(7);
        check("tps3_7", 32'(t_c), 32'h0002);
        pulse(0);
        ticks(3);
        check("tps3_pause", 32'(t_c), 32'h0002);
        check("tps3_pause_run", 32'(run_c), 32'd0);
        pulse(0);
        ticks(2);
        check("tps3_resume", 32'(t_c), 32'h0003);
        check("tps1_parallel", 32'(t_a), 32'h0009);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_c", 32'(t_c), 32'h0000);
        check("midrun_rst_run", 32'(run_c), 32'd0);
        check("midrun_rst_a", 32'(t_a), 32'h0000);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
